seq_run_ctrl: RTL and testbench

//  Run/step controller and trace buffer for the SEQ processor core.

---
 rtl/seq_run_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seq_run_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run/step controller and trace buffer for the SEQ core.
// Gates the core through a registered clock enable under command control and
// records {pc, alu} of every enabled cycle in a first-word-fall-through FIFO.
//
// Command handshake: cmd_valid is a single-cycle strobe with an implicit
// ready that is always 1. Every cycle with cmd_valid=1 is an accepted command.
// The state in which it arrives decides whether it acts or is ignored.
// The trace read side follows the same rule: trace_rd_en is a pop request
// that is honoured only while trace_empty=0.
module seq_run_ctrl #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_count,
    input  logic                     core_halt,
    input  logic [PC_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]        alu_in,
    output logic                     core_en,
    output logic [1:0]               state_out,
    input  logic                     trace_rd_en,
    output logic [PC_W+DATA_W-1:0]   trace_rd_data,
    output logic                     trace_empty,
    output logic                     trace_full,
    output logic                     trace_ovf,
    output logic [CNT_W-1:0]         cycles_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = PC_W + DATA_W;

    localparam logic [1:0] OP_STOP     = 2'd0;
    localparam logic [1:0] OP_STEP     = 2'd1;
    localparam logic [1:0] OP_RUN_N    = 2'd2;
    localparam logic [1:0] OP_RUN_FREE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             free_q, free_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [TW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_req, rd_fire, wr_fire;

    assign state_out = state_q;

    // Next-state logic: halt beats STOP, and STOP beats count expiry.
    always_comb begin
        state_d     = state_q;
        free_d      = free_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_STEP: begin
                            state_d     = ST_RUN;
                            remaining_d = CNT_W'(1);
                            free_d      = 1'b0;
                        end
                        OP_RUN_N: begin
                            if (cmd_count != '0) begin
                                state_d     = ST_RUN;
                                remaining_d = cmd_count;
                                free_d      = 1'b0;
                            end
                        end
                        OP_RUN_FREE: begin
                            state_d = ST_RUN;
                            free_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (core_halt) begin
                    state_d = ST_HALTED;
                end else if (cmd_valid && cmd_op == OP_STOP) begin
                    state_d     = ST_IDLE;
                    free_d      = 1'b0;
                    remaining_d = '0;
                end else if (!free_q) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                if (cmd_valid && cmd_op == OP_STOP) begin
                    state_d     = ST_IDLE;
                    free_d      = 1'b0;
                    remaining_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; core_en is the registered image of the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            free_q      <= 1'b0;
            remaining_q <= '0;
            core_en     <= 1'b0;
        end else begin
            state_q     <= state_d;
            free_q      <= free_d;
            remaining_q <= remaining_d;
            core_en     <= (state_d == ST_RUN);
        end
    end

    // Enabled-cycle counter, holds at all-ones.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cycles_out <= '0;
        end else if (core_en && cycles_out != '1) begin
            cycles_out <= cycles_out + CNT_W'(1);
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_req      = core_en;
    assign trace_empty = (wr_ptr == rd_ptr);
    assign trace_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire     = trace_rd_en && !trace_empty;
    assign wr_fire     = wr_req && (!trace_full || rd_fire);

    assign trace_rd_data = mem[rd_ptr[AW-1:0]];

    // Trace FIFO pointers and sticky overflow flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (wr_req && !wr_fire) trace_ovf <= 1'b1;
        end
    end

    // Trace storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= {pc_in, alu_in};
        end
    end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl: scenario tasks with a queue of expected trace entries.
module tb_seq_run_ctrl;

    localparam int PC_W = 32, DATA_W = 32, DEPTH = 16, CNT_W = 16;
    localparam int TW = PC_W + DATA_W;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_op = '0;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic              core_halt = 1'b0;
    logic [PC_W-1:0]   pc_in = '0;
    logic [DATA_W-1:0] alu_in = '0;
    logic              core_en;
    logic [1:0]        state_out;
    logic              trace_rd_en = 1'b0;
    logic [TW-1:0]     trace_rd_data;
    logic              trace_empty, trace_full, trace_ovf;
    logic [CNT_W-1:0]  cycles_out;

    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] e;
    int total = 0;
    int bad = 0;
    int n;

    seq_run_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .core_halt(core_halt), .pc_in(pc_in), .alu_in(alu_in),
        .core_en(core_en), .state_out(state_out), .trace_rd_en(trace_rd_en),
        .trace_rd_data(trace_rd_data), .trace_empty(trace_empty), .trace_full(trace_full),
        .trace_ovf(trace_ovf), .cycles_out(cycles_out)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        cmd_valid = 1'b0;
        core_halt = 1'b0;
        trace_rd_en = 1'b0;
        #3;
        RESET = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_data();
        pc_in = $urandom_range(32'h0000_0000, 32'hFFFF_FFF0);
        alu_in = $urandom;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        #3;
        total++;
        if (core_en !== 1'b0 || state_out !== 2'd0 || trace_empty !== 1'b1 || trace_full !== 1'b0 ||
            trace_ovf !== 1'b0 || cycles_out !== '0 || trace_rd_data !== '0) begin
            bad++;
            $display("FAIL reset_values en=%b st=%0d empty=%b full=%b ovf=%b cyc=%0d data=%h expected 0/0/1/0/0/0/0",
                     core_en, state_out, trace_empty, trace_full, trace_ovf, cycles_out, trace_rd_data);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        issue_cmd(2'd2, 16'd100);
        for (int i = 0; i < 40; i++) begin
            drive_data();
            tick();
        end
        total++;
        if (core_en !== 1'b1 || cycles_out !== 16'd40) begin
            bad++;
            $display("FAIL t1_pre_reset en=%b cyc=%0d expected 1/40", core_en, cycles_out);
        end
        #2 RESET = 1'b0;
        #1;
        total++;
        if (core_en !== 1'b0 || state_out !== 2'd0 || trace_empty !== 1'b1 || cycles_out !== '0) begin
            bad++;
            $display("FAIL t1_async_reset en=%b st=%0d empty=%b cyc=%0d expected 0/0/1/0",
                     core_en, state_out, trace_empty, cycles_out);
        end
        do_reset();
    endtask

    task automatic test_step();
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        total++;
        if (trace_empty !== 1'b1 || trace_rd_data !== '0) begin
            bad++;
            $display("FAIL t2_read_empty empty=%b data=%h expected 1/0", trace_empty, trace_rd_data);
        end
        total++;
        if (core_en !== 1'b0) begin
            bad++;
            $display("FAIL t2_pre_en got=%b expected 0", core_en);
        end
        issue_cmd(2'd1, 16'd0);
        pc_in = 32'h10;
        alu_in = $urandom;
        total++;
        if (core_en !== 1'b1 || state_out !== 2'd1) begin
            bad++;
            $display("FAIL t2_step_en en=%b st=%0d expected 1/1", core_en, state_out);
        end
        exp_q.push_back({pc_in, alu_in});
        tick();
        drive_data();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (core_en !== 1'b0 || state_out !== 2'd0) begin
                bad++;
                $display("FAIL t2_after_step%0d en=%b st=%0d expected 0/0", i, core_en, state_out);
            end
            tick();
        end
        total++;
        if (cycles_out !== 16'd1) begin
            bad++;
            $display("FAIL t2_cycles got=%0d expected 1", cycles_out);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            total++;
            if (trace_empty !== 1'b0 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t2_entry%0d got=%h empty=%b expected %h", k, trace_rd_data, trace_empty, e);
            end
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_empty !== 1'b1) begin
            bad++;
            $display("FAIL t2_drained empty=%b expected 1", trace_empty);
        end
    endtask

    task automatic test_run_n_overflow();
        do_reset();
        issue_cmd(2'd2, 16'd20);
        for (int i = 0; i < 20; i++) begin
            drive_data();
            total++;
            if (core_en !== 1'b1) begin
                bad++;
                $display("FAIL t3_en_cycle%0d got=%b expected 1", i, core_en);
            end
            if (exp_q.size() < DEPTH) exp_q.push_back({pc_in, alu_in});
            tick();
        end
        total++;
        if (core_en !== 1'b0 || state_out !== 2'd0 || trace_full !== 1'b1 || trace_ovf !== 1'b1 ||
            cycles_out !== 16'd20) begin
            bad++;
            $display("FAIL t3_end en=%b st=%0d full=%b ovf=%b cyc=%0d expected 0/0/1/1/20",
                     core_en, state_out, trace_full, trace_ovf, cycles_out);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            total++;
            if (trace_empty !== 1'b0 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t3_entry%0d got=%h empty=%b expected %h", k, trace_rd_data, trace_empty, e);
            end
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_empty !== 1'b1 || trace_ovf !== 1'b1) begin
            bad++;
            $display("FAIL t3_drained empty=%b ovf=%b expected 1/1", trace_empty, trace_ovf);
        end
    endtask

    task automatic test_halt();
        do_reset();
        issue_cmd(2'd3, 16'd0);
        for (int i = 0; i < 7; i++) begin
            drive_data();
            core_halt = (i == 6);
            total++;
            if (core_en !== 1'b1) begin
                bad++;
                $display("FAIL t4_en_cycle%0d got=%b expected 1", i, core_en);
            end
            exp_q.push_back({pc_in, alu_in});
            tick();
        end
        core_halt = 1'b0;
        total++;
        if (state_out !== 2'd2 || core_en !== 1'b0) begin
            bad++;
            $display("FAIL t4_halted st=%0d en=%b expected 2/0", state_out, core_en);
        end
        issue_cmd(2'd1, 16'd0);
        tick();
        total++;
        if (state_out !== 2'd2 || core_en !== 1'b0) begin
            bad++;
            $display("FAIL t4_step_ignored st=%0d en=%b expected 2/0", state_out, core_en);
        end
        issue_cmd(2'd0, 16'd0);
        total++;
        if (state_out !== 2'd0 || core_en !== 1'b0 || cycles_out !== 16'd7) begin
            bad++;
            $display("FAIL t4_stop st=%0d en=%b cyc=%0d expected 0/0/7", state_out, core_en, cycles_out);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            total++;
            if (trace_empty !== 1'b0 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t4_entry%0d got=%h empty=%b expected %h", k, trace_rd_data, trace_empty, e);
            end
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_empty !== 1'b1) begin
            bad++;
            $display("FAIL t4_drained empty=%b expected 1", trace_empty);
        end
    endtask

    task automatic test_run0_and_stop();
        do_reset();
        issue_cmd(2'd2, 16'd0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (core_en !== 1'b0 || state_out !== 2'd0) begin
                bad++;
                $display("FAIL t5_run0_%0d en=%b st=%0d expected 0/0", i, core_en, state_out);
            end
            tick();
        end
        issue_cmd(2'd3, 16'd0);
        for (int i = 0; i < 3; i++) begin
            drive_data();
            total++;
            if (core_en !== 1'b1) begin
                bad++;
                $display("FAIL t5_en_cycle%0d got=%b expected 1", i, core_en);
            end
            exp_q.push_back({pc_in, alu_in});
            if (i == 2) begin
                cmd_valid = 1'b1;
                cmd_op = 2'd0;
            end
            tick();
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (core_en !== 1'b0 || state_out !== 2'd0) begin
                bad++;
                $display("FAIL t5_stopped%0d en=%b st=%0d expected 0/0", i, core_en, state_out);
            end
            tick();
        end
        total++;
        if (cycles_out !== 16'd3) begin
            bad++;
            $display("FAIL t5_cycles got=%0d expected 3", cycles_out);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            total++;
            if (trace_empty !== 1'b0 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t5_entry%0d got=%h empty=%b expected %h", k, trace_rd_data, trace_empty, e);
            end
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_empty !== 1'b1) begin
            bad++;
            $display("FAIL t5_drained empty=%b expected 1", trace_empty);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_cmd(2'd2, 16'd16);
        for (int i = 0; i < 16; i++) begin
            drive_data();
            exp_q.push_back({pc_in, alu_in});
            tick();
        end
        total++;
        if (trace_full !== 1'b1 || trace_ovf !== 1'b0 || core_en !== 1'b0) begin
            bad++;
            $display("FAIL t6_filled full=%b ovf=%b en=%b expected 1/0/0", trace_full, trace_ovf, core_en);
        end
        issue_cmd(2'd2, 16'd8);
        for (int i = 0; i < 8; i++) begin
            drive_data();
            trace_rd_en = 1'b1;
            e = exp_q.pop_front();
            total++;
            if (core_en !== 1'b1 || trace_full !== 1'b1 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t6_rw%0d en=%b full=%b got=%h expected 1/1/%h", i, core_en, trace_full, trace_rd_data, e);
            end
            exp_q.push_back({pc_in, alu_in});
            tick();
        end
        trace_rd_en = 1'b0;
        total++;
        if (trace_ovf !== 1'b0 || trace_full !== 1'b1 || cycles_out !== 16'd24) begin
            bad++;
            $display("FAIL t6_after ovf=%b full=%b cyc=%0d expected 0/1/24", trace_ovf, trace_full, cycles_out);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            total++;
            if (trace_empty !== 1'b0 || trace_rd_data !== e) begin
                bad++;
                $display("FAIL t6_entry%0d got=%h empty=%b expected %h", k, trace_rd_data, trace_empty, e);
            end
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_empty !== 1'b1 || trace_ovf !== 1'b0) begin
            bad++;
            $display("FAIL t6_drained empty=%b ovf=%b expected 1/0", trace_empty, trace_ovf);
        end
    endtask

    // scenario sequence and final report
    initial begin
        test_reset();
        test_reset_mid_run();
        test_step();
        test_run_n_overflow();
        test_halt();
        test_run0_and_stop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
